parking_controller: RTL

Parametrised parking-lot controller: filters the entry and exit car sensors, allocates the lowest-numbered free slot to each entering car, releases the operator-selected slot on exit, and drives the door, full indicator, free-capacity count and best-place index. It replaces the fixed four-slot parking top and sits between the sensor/switch inputs and the seven-segment display driver. It runs on the system clock and uses no divided clocks.

---
 rtl/parking_controller_if.sv | 41 ++++
 rtl/parking_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/parking_controller_if.sv
// Sensor, slot-select and status signals of the parking-lot controller.
// PARKING_STATS_EN adds the entries_total/rejects_total statistic counters.
interface parking_controller_if #(
  parameter int SLOTS = 4
);
  localparam int IW = $clog2(SLOTS + 1);

  logic             entry_sensor;
  logic             exit_sensor;
  logic [IW-1:0]    slot_sel;
  logic [SLOTS-1:0] parking_slots;
  logic             door_open;
  logic             full_light;
  logic [IW-1:0]    capacity;
  logic [IW-1:0]    best_place;
  logic             error;
`ifdef PARKING_STATS_EN
  logic [15:0]      entries_total;
  logic [15:0]      rejects_total;

  modport master (
    output entry_sensor, exit_sensor, slot_sel,
    input  parking_slots, door_open, full_light, capacity, best_place, error,
           entries_total, rejects_total
  );
  modport slave (
    input  entry_sensor, exit_sensor, slot_sel,
    output parking_slots, door_open, full_light, capacity, best_place, error,
           entries_total, rejects_total
  );
`else
  modport master (
    output entry_sensor, exit_sensor, slot_sel,
    input  parking_slots, door_open, full_light, capacity, best_place, error
  );
  modport slave (
    input  entry_sensor, exit_sensor, slot_sel,
    output parking_slots, door_open, full_light, capacity, best_place, error
  );
`endif
endinterface

// File: rtl/parking_controller.sv
// Parking-lot controller: sensor sync/debounce, lowest-free-slot allocation, door pulse.
// Optional statistics counters are enabled with PARKING_STATS_EN.
module parking_controller #(
  parameter int SLOTS       = 4,
  parameter int DEBOUNCE    = 2,
  parameter int DOOR_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parking_controller_if.slave  bus
);
  localparam int IW = $clog2(SLOTS + 1);
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  typedef enum logic {IDLE, DOOR} state_t;

  // Sensor pipelines: index 0 is the entry sensor, index 1 the exit sensor.
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         deb_q, deb_d;
  logic [1:0]         deb_prev_q, deb_prev_d;
  logic [1:0]         evt_q, evt_d;
  logic [1:0][DW-1:0] cnt_q, cnt_d;

  state_t             state_q, state_d;
  logic [CW-1:0]      door_cnt_q, door_cnt_d;
  logic [SLOTS-1:0]   occ_q, occ_d;
  logic               err_q, err_d;
  logic               full_q, full_d;
  logic [IW-1:0]      capacity_c;
  logic [IW-1:0]      best_c;
  logic               sel_hit;
`ifdef PARKING_STATS_EN
  logic [15:0]        entries_q, entries_d;
  logic [15:0]        rejects_q, rejects_d;
`endif

  always_comb begin
    sync1_d    = {bus.exit_sensor, bus.entry_sensor};
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    cnt_d      = cnt_q;
    deb_prev_d = deb_q;
    evt_d      = deb_q & ~deb_prev_q;
    for (int s = 0; s < 2; s++) begin
      if (sync2_q[s] != deb_q[s]) begin
        if (cnt_q[s] == DW'(DEBOUNCE - 1)) begin
          deb_d[s] = sync2_q[s];
          cnt_d[s] = '0;
        end else begin
          cnt_d[s] = cnt_q[s] + 1'b1;
        end
      end else begin
        cnt_d[s] = '0;
      end
    end
  end

  // Free-slot count and lowest free slot, both straight from the occupancy register.
  always_comb begin
    int free_cnt;
    free_cnt = 0;
    best_c   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!occ_q[i]) begin
        free_cnt = free_cnt + 1;
        best_c   = IW'(i + 1);
      end
    end
    capacity_c = IW'(free_cnt);
  end

  always_comb begin
    sel_hit = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (bus.slot_sel == IW'(i + 1) && occ_q[i]) sel_hit = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    door_cnt_d = door_cnt_q;
    occ_d      = occ_q;
    err_d      = 1'b0;
    full_d     = (capacity_c == '0) && deb_q[0] && !deb_q[1];
`ifdef PARKING_STATS_EN
    entries_d  = entries_q;
    rejects_d  = rejects_q;
`endif
    case (state_q)
      IDLE: begin
        if (evt_q[1]) begin
          if (sel_hit) begin
            for (int i = 0; i < SLOTS; i++) begin
              if (bus.slot_sel == IW'(i + 1)) occ_d[i] = 1'b0;
            end
            state_d    = DOOR;
            door_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end else if (evt_q[0]) begin
          if (capacity_c != '0) begin
            for (int i = 0; i < SLOTS; i++) begin
              if (best_c == IW'(i + 1)) occ_d[i] = 1'b1;
            end
            state_d    = DOOR;
            door_cnt_d = '0;
`ifdef PARKING_STATS_EN
            if (entries_q != 16'hFFFF) entries_d = entries_q + 16'd1;
`endif
          end else begin
            err_d = 1'b1;
`ifdef PARKING_STATS_EN
            if (rejects_q != 16'hFFFF) rejects_d = rejects_q + 16'd1;
`endif
          end
        end
      end
      DOOR: begin
        if (door_cnt_q == CW'(DOOR_CYCLES - 1)) begin
          state_d    = IDLE;
          door_cnt_d = '0;
        end else begin
          door_cnt_d = door_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      evt_q      <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      door_cnt_q <= '0;
      occ_q      <= '0;
      err_q      <= 1'b0;
      full_q     <= 1'b0;
`ifdef PARKING_STATS_EN
      entries_q  <= '0;
      rejects_q  <= '0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      evt_q      <= evt_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      door_cnt_q <= door_cnt_d;
      occ_q      <= occ_d;
      err_q      <= err_d;
      full_q     <= full_d;
`ifdef PARKING_STATS_EN
      entries_q  <= entries_d;
      rejects_q  <= rejects_d;
`endif
    end
  end

  assign bus.parking_slots = occ_q;
  assign bus.door_open     = (state_q == DOOR);
  assign bus.full_light    = full_q;
  assign bus.capacity      = capacity_c;
  assign bus.best_place    = best_c;
  assign bus.error         = err_q;
`ifdef PARKING_STATS_EN
  assign bus.entries_total = entries_q;
  assign bus.rejects_total = rejects_q;
`endif

endmodule
